// File: rtl/reservation_station_pkg.sv
// Shared widths and the entry record for the reservation station.
// Entry widths are fixed here; the top-level width parameters default to them.
package reservation_station_pkg;

  localparam int TAG_W     = 4;
  localparam int DATA_W    = 16;
  localparam int OPC_W     = 4;
  localparam int MAX_DEPTH = 8;
  localparam int RANK_W    = $clog2(MAX_DEPTH);

  typedef struct packed {
    logic              busy;
    logic [OPC_W-1:0]  opcode;
    logic [TAG_W-1:0]  tag;
    logic              a_valid;
    logic [DATA_W-1:0] a_value;
    logic [TAG_W-1:0]  a_owner;
    logic              b_valid;
    logic [DATA_W-1:0] b_value;
    logic [TAG_W-1:0]  b_owner;
    logic [RANK_W-1:0] rank;
  } rs_entry_t;

endpackage

// File: rtl/reservation_station_select.sv
// Combinational picker: among ready entries, grants the one with the lowest
// age rank. Ranks of occupied entries are unique, so the winner is unique.
module rs_select
  import reservation_station_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]              i_ready,
  input  logic [DEPTH-1:0][RANK_W-1:0]  i_rank,
  output logic                          o_valid,
  output logic [DEPTH-1:0]              o_grant,
  output logic [$clog2(DEPTH)-1:0]      o_index
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [RANK_W-1:0] w_best;

  // NOTE: always_comb uses blocking assignments with a default for every
  // output first, so no path leaves a variable unassigned (no latch).
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    w_best  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_ready[i] && (!o_valid || (i_rank[i] < w_best))) begin
        o_valid = 1'b1;
        o_index = IDX_W'(i);
        w_best  = i_rank[i];
      end
    end
    o_grant = o_valid ? (DEPTH'(1) << o_index) : '0;
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched ops until both operands are valid
// (directly or via CDB wakeup) and issues the oldest ready op.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = reservation_station_pkg::TAG_W,
  parameter int DATA_W = reservation_station_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [OPC_W-1:0]         in_opcode,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic                     in_a_valid,
  input  logic [DATA_W-1:0]        in_a_value,
  input  logic [TAG_W-1:0]         in_a_owner,
  input  logic                     in_b_valid,
  input  logic [DATA_W-1:0]        in_b_value,
  input  logic [TAG_W-1:0]         in_b_owner,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [DATA_W-1:0]        cdb_value,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [OPC_W-1:0]         issue_opcode,
  output logic [TAG_W-1:0]         issue_tag,
  output logic [DATA_W-1:0]        issue_a,
  output logic [DATA_W-1:0]        issue_b
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  rs_entry_t                    r_ent [DEPTH];
  logic [DEPTH-1:0]             w_ready;
  logic [DEPTH-1:0][RANK_W-1:0] w_rank;
  logic [DEPTH-1:0]             w_grant;
  logic [DEPTH-1:0]             w_free_oh;
  logic                         w_free_found;
  logic [IDX_W-1:0]             w_sel;
  logic                         w_fire;
  logic                         w_accept;
  logic                         w_a_hit;
  logic                         w_b_hit;
  logic [RANK_W-1:0]            w_leave_rank;
  rs_entry_t                    w_new;

  always_comb begin
    count        = '0;
    w_free_oh    = '0;
    w_free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_ready[i] = r_ent[i].busy && r_ent[i].a_valid && r_ent[i].b_valid;
      w_rank[i]  = r_ent[i].rank;
      count      = count + CNT_W'(r_ent[i].busy);
      if (!r_ent[i].busy && !w_free_found) begin
        w_free_oh[i] = 1'b1;
        w_free_found = 1'b1;
      end
    end
  end

  assign full = (count == CNT_W'(DEPTH));

  rs_select #(.DEPTH(DEPTH)) u_select (
    .i_ready (w_ready),
    .i_rank  (w_rank),
    .o_valid (issue_valid),
    .o_grant (w_grant),
    .o_index (w_sel)
  );

  assign issue_opcode = r_ent[w_sel].opcode;
  assign issue_tag    = r_ent[w_sel].tag;
  assign issue_a      = r_ent[w_sel].a_value;
  assign issue_b      = r_ent[w_sel].b_value;

  assign w_fire       = issue_valid && issue_ready;
  assign w_accept     = in_valid && !full && !flush;
  assign w_leave_rank = r_ent[w_sel].rank;
  assign w_a_hit      = cdb_valid && !in_a_valid && (in_a_owner == cdb_tag);
  assign w_b_hit      = cdb_valid && !in_b_valid && (in_b_owner == cdb_tag);

  // A new entry is conceptually appended at rank=count and shifts down with
  // everyone else when an older entry issues in the same cycle.
  always_comb begin
    w_new         = '0;
    w_new.busy    = 1'b1;
    w_new.opcode  = in_opcode;
    w_new.tag     = in_tag;
    w_new.a_valid = in_a_valid || w_a_hit;
    w_new.a_value = w_a_hit ? cdb_value : in_a_value;
    w_new.a_owner = in_a_owner;
    w_new.b_valid = in_b_valid || w_b_hit;
    w_new.b_value = w_b_hit ? cdb_value : in_b_value;
    w_new.b_owner = in_b_owner;
    w_new.rank    = RANK_W'(count) - RANK_W'(w_fire);
  end

  // NOTE: sequential state uses non-blocking assignments only. Reset and flush
  // clear just the busy bits; payload of a free entry is never observed.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i].busy <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_fire && w_grant[i]) begin
          r_ent[i].busy <= 1'b0;
        end else if (r_ent[i].busy) begin
          if (w_fire && (r_ent[i].rank > w_leave_rank))
            r_ent[i].rank <= r_ent[i].rank - RANK_W'(1);
          if (cdb_valid && !r_ent[i].a_valid && (r_ent[i].a_owner == cdb_tag)) begin
            r_ent[i].a_valid <= 1'b1;
            r_ent[i].a_value <= cdb_value;
          end
          if (cdb_valid && !r_ent[i].b_valid && (r_ent[i].b_owner == cdb_tag)) begin
            r_ent[i].b_valid <= 1'b1;
            r_ent[i].b_value <= cdb_value;
          end
        end else if (w_accept && w_free_oh[i]) begin
          r_ent[i] <= w_new;
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: an age-ordered queue model checked every
// cycle, plus directed sequences with literal expectations.
module tb_reservation_station;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [3:0]  in_opcode;
  logic [3:0]  in_tag;
  logic        in_a_valid;
  logic [15:0] in_a_value;
  logic [3:0]  in_a_owner;
  logic        in_b_valid;
  logic [15:0] in_b_value;
  logic [3:0]  in_b_owner;
  logic        full;
  logic [2:0]  count;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [15:0] cdb_value;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_opcode;
  logic [3:0]  issue_tag;
  logic [15:0] issue_a;
  logic [15:0] issue_b;

  reservation_station #(.DEPTH(DEPTH), .TAG_W(4), .DATA_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_opcode    (in_opcode),
    .in_tag       (in_tag),
    .in_a_valid   (in_a_valid),
    .in_a_value   (in_a_value),
    .in_a_owner   (in_a_owner),
    .in_b_valid   (in_b_valid),
    .in_b_value   (in_b_value),
    .in_b_owner   (in_b_owner),
    .full         (full),
    .count        (count),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_value    (cdb_value),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_opcode (issue_opcode),
    .issue_tag    (issue_tag),
    .issue_a      (issue_a),
    .issue_b      (issue_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue in age order, index 0 is the oldest entry.
  typedef struct {
    logic [3:0]  op;
    logic [3:0]  tag;
    bit          av;
    logic [15:0] a;
    logic [3:0]  ao;
    bit          bv;
    logic [15:0] b;
    logic [3:0]  bo;
  } m_ent_t;

  m_ent_t mq[$];
  bit     known = 1'b0;

  function automatic int m_sel();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].av && mq[i].bv) return i;
    return -1;
  endfunction

  always @(posedge clk) begin : model_upd
    int     s;
    bit     was_full;
    m_ent_t n;
    if (rst) begin
      mq.delete();
      known = 1'b1;
    end else if (flush) begin
      mq.delete();
    end else begin
      s        = m_sel();
      was_full = (mq.size() == DEPTH);
      for (int i = 0; i < mq.size(); i++) begin
        if (cdb_valid && !mq[i].av && mq[i].ao == cdb_tag) begin mq[i].av = 1; mq[i].a = cdb_value; end
        if (cdb_valid && !mq[i].bv && mq[i].bo == cdb_tag) begin mq[i].bv = 1; mq[i].b = cdb_value; end
      end
      if (s >= 0 && issue_ready) mq.delete(s);
      if (in_valid && !was_full) begin
        n.op = in_opcode; n.tag = in_tag;
        n.av = in_a_valid; n.a = in_a_value; n.ao = in_a_owner;
        n.bv = in_b_valid; n.b = in_b_value; n.bo = in_b_owner;
        if (cdb_valid && !n.av && n.ao == cdb_tag) begin n.av = 1; n.a = cdb_value; end
        if (cdb_valid && !n.bv && n.bo == cdb_tag) begin n.bv = 1; n.b = cdb_value; end
        mq.push_back(n);
      end
    end
  end

  always @(negedge clk) begin : compare
    int s;
    if (known) begin
      s = m_sel();
      check("count", 32'(count), 32'(mq.size()));
      check("full", 32'(full), 32'(mq.size() == DEPTH));
      check("issue_valid", 32'(issue_valid), 32'(s >= 0));
      if (s >= 0) begin
        check("issue_opcode", 32'(issue_opcode), 32'(mq[s].op));
        check("issue_tag", 32'(issue_tag), 32'(mq[s].tag));
        check("issue_a", 32'(issue_a), 32'(mq[s].a));
        check("issue_b", 32'(issue_b), 32'(mq[s].b));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_a_valid = 1'b0;
    in_b_valid = 1'b0;
  endtask

  task automatic disp(input logic [3:0] tag, input bit av, input logic [15:0] a,
                      input logic [3:0] ao, input bit bv, input logic [15:0] b,
                      input logic [3:0] bo);
    in_valid   = 1'b1;
    in_opcode  = tag ^ 4'h5;
    in_tag     = tag;
    in_a_valid = av; in_a_value = a; in_a_owner = ao;
    in_b_valid = bv; in_b_value = b; in_b_owner = bo;
  endtask

  task automatic disp_rdy(input logic [3:0] tag);
    disp(tag, 1'b1, {12'h0A0, tag}, 4'h0, 1'b1, {12'h0B0, tag}, 4'h0);
  endtask

  task automatic wake(input logic [3:0] tag, input logic [15:0] val);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = val;
  endtask

  task automatic fill3_then(input bit use_rst);
    issue_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin disp_rdy(4'(t)); tick(); end
    disp_rdy(4'd4);
    issue_ready = 1'b1;
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; idle();
    check(use_rst ? "rst_count" : "flush_count", 32'(count), 32'd0);
    check(use_rst ? "rst_issue_valid" : "flush_issue_valid", 32'(issue_valid), 32'd0);
    tick();
    check(use_rst ? "rst_count_after" : "flush_count_after", 32'(count), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; issue_ready = 1'b0;
    in_opcode = '0; in_tag = '0; in_a_value = '0; in_a_owner = '0;
    in_b_value = '0; in_b_owner = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    idle();
    tick(); tick();
    check("reset_count", 32'(count), 32'd0);
    check("reset_full", 32'(full), 32'd0);
    check("reset_issue_valid", 32'(issue_valid), 32'd0);
    rst = 1'b0;

    // Fill to capacity, drop a fifth dispatch, hold issue stable.
    for (int t = 1; t <= 4; t++) begin disp_rdy(4'(t)); tick(); end
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd4);
    disp_rdy(4'd9); tick();
    check("drop_count", 32'(count), 32'd4);
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_tag", 32'(issue_tag), 32'd1);
      check("hold_a", 32'(issue_a), 32'h0A01);
      check("hold_opcode", 32'(issue_opcode), 32'h4);
    end

    // Issue while full with a concurrent dispatch: dispatch dropped.
    issue_ready = 1'b1; disp_rdy(4'd8); tick();
    check("full_issue_count", 32'(count), 32'd3);
    check("full_issue_next_tag", 32'(issue_tag), 32'd2);
    disp_rdy(4'd8); tick();
    check("disp_issue_count", 32'(count), 32'd3);
    check("disp_issue_tag", 32'(issue_tag), 32'd3);
    idle();
    tick(); check("drain_tag4", 32'(issue_tag), 32'd4);
    tick(); check("drain_tag8", 32'(issue_tag), 32'd8);
    tick(); check("drain_empty", 32'(issue_valid), 32'd0);

    // Younger ready op issues before an older waiting one; wakeup then issues.
    issue_ready = 1'b0;
    disp(4'd5, 1'b0, 16'h0000, 4'd7, 1'b1, 16'h0055, 4'd0); tick();
    disp_rdy(4'd6); tick();
    check("bypass_young_tag", 32'(issue_tag), 32'd6);
    idle(); issue_ready = 1'b1; tick();
    check("waiting_not_valid", 32'(issue_valid), 32'd0);
    wake(4'd7, 16'h1234); tick(); cdb_valid = 1'b0;
    check("wake_valid", 32'(issue_valid), 32'd1);
    check("wake_tag", 32'(issue_tag), 32'd5);
    check("wake_a", 32'(issue_a), 32'h1234);
    tick();
    check("wake_drain", 32'(count), 32'd0);

    // Dispatch-time bypass from the CDB.
    issue_ready = 1'b0;
    disp(4'd2, 1'b0, 16'h0000, 4'd3, 1'b1, 16'h0002, 4'd0);
    wake(4'd3, 16'hBEEF); tick();
    cdb_valid = 1'b0; idle();
    check("bypass_valid", 32'(issue_valid), 32'd1);
    check("bypass_a", 32'(issue_a), 32'hBEEF);
    issue_ready = 1'b1; tick();

    // Rank bookkeeping across issue+dispatch and out-of-order wakeups.
    issue_ready = 1'b0;
    disp_rdy(4'd10); tick();
    disp(4'd11, 1'b0, 16'h0000, 4'd12, 1'b1, 16'h00B1, 4'd0); tick();
    issue_ready = 1'b1;
    disp(4'd12, 1'b0, 16'h0000, 4'd13, 1'b1, 16'h00C1, 4'd0); tick();
    check("rank_count2", 32'(count), 32'd2);
    issue_ready = 1'b0; disp_rdy(4'd13); tick();
    idle(); wake(4'd13, 16'h0C0C); tick();
    check("rank_c_before_d", 32'(issue_tag), 32'd12);
    wake(4'd12, 16'h0B0B); tick(); cdb_valid = 1'b0;
    check("rank_b_oldest", 32'(issue_tag), 32'd11);
    check("rank_b_a", 32'(issue_a), 32'h0B0B);
    issue_ready = 1'b1;
    tick(); check("rank_then_c", 32'(issue_tag), 32'd12);
    tick(); check("rank_then_d", 32'(issue_tag), 32'd13);
    tick(); check("rank_empty", 32'(count), 32'd0);

    // Flush, then reset, each with a concurrent dispatch and issue.
    fill3_then(1'b0);
    fill3_then(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
